// File: rtl/ov7670_stream_tx_if.sv
// Camera-side stream bundle for ov7670_stream_tx: control in, pixel source handshake,
// OV7670-style output bus and status. master = the transmitter, slave = its environment.
interface ov7670_stream_tx_if;
  logic        start;
  logic        continuous;
  logic        pattern_en;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pclk_out;
  logic        vsync_out;
  logic        href_out;
  logic [7:0]  data_out;
  logic [9:0]  x_count;
  logic [8:0]  y_count;
  logic        busy;
  logic        frame_done;
  logic        underrun;
  logic [2:0]  state_dbg;

  // Pixel handshake: a pixel moves when pix_valid and pix_ready are both high at a clk edge.
  // pix_ready is a one-cycle strobe and does not wait for pix_valid; a missing pixel is an underrun.
  modport master (
    input  start, continuous, pattern_en, pix_data, pix_valid,
    output pix_ready, pclk_out, vsync_out, href_out, data_out,
    output x_count, y_count, busy, frame_done, underrun, state_dbg
  );

  modport slave (
    output start, continuous, pattern_en, pix_data, pix_valid,
    input  pix_ready, pclk_out, vsync_out, href_out, data_out,
    input  x_count, y_count, busy, frame_done, underrun, state_dbg
  );
endinterface

// File: rtl/ov7670_stream_tx.sv
// OV7670-style frame transmitter: emits vsync/href/byte stream at clk/2, RGB565 pixels
// taken from a ready/valid source or an internal test pattern.
module ov7670_stream_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input logic               clk,
  input logic               reset,
  ov7670_stream_tx_if.master bus
);

  localparam int LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
  localparam int HW         = $clog2(LINE_SLOTS + 1);
  localparam int LW         = 10;

  localparam logic [HW-1:0] H_LAST   = HW'(LINE_SLOTS - 1);
  localparam logic [HW-1:0] ACT_LAST = HW'(2 * H_ACTIVE - 1);
  localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VB_LAST  = LW'(V_BACK - 1);
  localparam logic [LW-1:0] VF_LAST  = LW'(V_FRONT - 1);
  localparam logic [8:0]    Y_LAST   = 9'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_t;

  state_t        state_q, state_d;
  logic          pclk_q, pclk_d;
  logic [HW-1:0] h_q, h_d;
  logic [LW-1:0] l_q, l_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    lo_q, lo_d;
  logic          pat_q, pat_d;
  logic          underrun_q, underrun_d;
  logic          frame_done_q, frame_done_d;

  logic          line_end;
  logic          enter_active;
  logic          launch;
  logic          pat_sel;
  logic          pix_ready_c;
  logic [15:0]   pixel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pclk_q       <= 1'b0;
      h_q          <= '0;
      l_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      data_q       <= '0;
      lo_q         <= '0;
      pat_q        <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pclk_q       <= pclk_d;
      h_q          <= h_d;
      l_q          <= l_d;
      x_q          <= x_d;
      y_q          <= y_d;
      data_q       <= data_d;
      lo_q         <= lo_d;
      pat_q        <= pat_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  // A slot edge is the clk edge on which pclk falls; nothing but pclk and
  // the frame_done pulse moves on the other edge.
  always_comb begin
    state_d      = state_q;
    pclk_d       = ~pclk_q;
    h_d          = h_q;
    l_d          = l_q;
    x_d          = x_q;
    y_d          = y_q;
    data_d       = data_q;
    lo_d         = lo_q;
    pat_d        = pat_q;
    underrun_d   = underrun_q;
    frame_done_d = 1'b0;
    enter_active = 1'b0;
    launch       = 1'b0;
    pix_ready_c  = 1'b0;
    pixel        = '0;
    line_end     = (h_q == H_LAST);

    if (pclk_q) begin
      h_d = line_end ? '0 : h_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          h_d = '0;
          l_d = '0;
          if (bus.start) state_d = S_VSYNC;
        end
        S_VSYNC: if (line_end) begin
          if (l_q == VS_LAST) begin
            state_d = S_VBACK;
            l_d     = '0;
          end else l_d = l_q + 1'b1;
        end
        S_VBACK: if (line_end) begin
          if (l_q == VB_LAST) begin
            state_d      = S_ACTIVE;
            l_d          = '0;
            enter_active = 1'b1;
          end else l_d = l_q + 1'b1;
        end
        S_ACTIVE: begin
          if (h_q == ACT_LAST) begin
            state_d = S_HBLANK;
            x_d     = '0;
          end else if (h_q[0]) begin
            launch = 1'b1;
            x_d    = x_q + 1'b1;
          end
        end
        S_HBLANK: if (line_end) begin
          if (y_q == Y_LAST) begin
            state_d = S_VFRONT;
            y_d     = '0;
          end else begin
            state_d      = S_ACTIVE;
            y_d          = y_q + 1'b1;
            enter_active = 1'b1;
          end
        end
        S_VFRONT: if (line_end) begin
          if (l_q == VF_LAST) begin
            l_d          = '0;
            frame_done_d = 1'b1;
            state_d      = bus.continuous ? S_VSYNC : S_IDLE;
          end else l_d = l_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Byte path: high byte is launched from a fresh pixel, low byte replays the held half.
    pat_sel = enter_active ? bus.pattern_en : pat_q;
    if (enter_active) pat_d = bus.pattern_en;
    if (pclk_q) begin
      data_d = 8'h00;
      if (enter_active || launch) begin
        if (pat_sel) begin
          pixel = {y_d[4:0], x_d[5:0], x_d[4:0]};
        end else begin
          pix_ready_c = 1'b1;
          pixel       = bus.pix_valid ? bus.pix_data : 16'h0000;
          if (!bus.pix_valid) underrun_d = 1'b1;
        end
        data_d = pixel[15:8];
        lo_d   = pixel[7:0];
      end else if (state_q == S_ACTIVE && !h_q[0]) begin
        data_d = lo_q;
      end
    end
  end

  assign bus.pix_ready  = pix_ready_c;
  assign bus.pclk_out   = pclk_q;
  assign bus.vsync_out  = (state_q == S_VSYNC);
  assign bus.href_out   = (state_q == S_ACTIVE);
  assign bus.data_out   = data_q;
  assign bus.x_count    = x_q;
  assign bus.y_count    = y_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.underrun   = underrun_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Bench for ov7670_stream_tx on a tiny 4x2 frame: byte scoreboard plus timing counters
// for vsync/href/pix_ready/frame_done.
module tb_ov7670_stream_tx;

  logic clk;
  logic reset;
  ov7670_stream_tx_if bus();

  ov7670_stream_tx #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  int vs_clks, href_clks, href_rises, rdy_clks, rdy_rises, fd_cnt, vs_rises;
  int vs_rise_cyc[2];
  int href_rise_cyc[2];
  int fd_cyc[2];
  int fd_vs[2];
  int fd_busy, idle_gap, pix_idx;
  logic href_prev, vs_prev, rdy_prev;
  logic drop_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    vs_clks = 0; href_clks = 0; href_rises = 0; rdy_clks = 0; rdy_rises = 0;
    fd_cnt = 0; vs_rises = 0; fd_busy = 0; idle_gap = 0; pix_idx = 0;
    for (int i = 0; i < 2; i++) begin
      vs_rise_cyc[i] = -1; href_rise_cyc[i] = -1; fd_cyc[i] = -1; fd_vs[i] = -1;
    end
  endtask

  // Pattern pixel for line y, pixel x is {y[4:0], x[5:0], x[4:0]}, high byte first.
  task automatic push_pattern_frame();
    logic [15:0] p;
    logic [9:0]  xv;
    logic [8:0]  yv;
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        xv = 10'(x);
        yv = 9'(y);
        p  = {yv[4:0], xv[5:0], xv[4:0]};
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
  endtask

  task automatic push_src_frame(input logic drop_third);
    for (int i = 0; i < 8; i++) begin
      if (drop_third && i == 2) begin
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
      end else begin
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hC3);
      end
    end
  endtask

  // ---------------- monitor (negedge sampling) ----------------
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.vsync_out) vs_clks++;
      if (bus.href_out) href_clks++;
      if (bus.pix_ready) rdy_clks++;
      if (bus.vsync_out && !vs_prev) begin
        if (vs_rises < 2) vs_rise_cyc[vs_rises] = cyc;
        vs_rises++;
      end
      if (bus.href_out && !href_prev) begin
        if (href_rises < 2) href_rise_cyc[href_rises] = cyc;
        href_rises++;
      end
      if (bus.pix_ready && !rdy_prev) rdy_rises++;
      if (bus.pix_ready) pix_idx++;
      if (bus.frame_done) begin
        if (fd_cnt < 2) begin
          fd_cyc[fd_cnt] = cyc;
          fd_vs[fd_cnt]  = int'(bus.vsync_out);
        end
        fd_busy = int'(bus.busy);
        fd_cnt++;
      end
      if (vs_rises >= 1 && fd_cnt < 2 && !bus.busy) idle_gap++;
      if (bus.pclk_out) begin
        if (bus.href_out) begin
          if (exp_q.size() == 0) check("extra_byte", 32'(bus.data_out), 32'hFFFF_FFFF);
          else check("data_byte", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end else begin
          check("data_idle_zero", 32'(bus.data_out), 32'h0);
        end
      end
    end
    href_prev = bus.href_out;
    vs_prev   = bus.vsync_out;
    rdy_prev  = bus.pix_ready;
  end

  // ---------------- pixel source driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.pix_valid = !(drop_en && pix_idx == 2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_timeout", 32'(fd_cnt >= target), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset          = 1'b1;
    drop_en        = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.pattern_en = 1'b1;
    bus.pix_data   = 16'hA5C3;
    bus.pix_valid  = 1'b1;
    href_prev = 0; vs_prev = 0; rdy_prev = 0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_pclk", 32'(bus.pclk_out), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_vsync_href", {bus.vsync_out, bus.href_out}, 0);
    check("rst_data", 32'(bus.data_out), 0);
    check("rst_xy", {bus.x_count, bus.y_count}, 0);
    check("rst_flags", {bus.frame_done, bus.underrun, bus.pix_ready}, 0);
    check("rst_state", 32'(bus.state_dbg), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // single pattern frame
    clear_mon();
    push_pattern_frame();
    pulse_start();
    wait_fd(1, 400);
    repeat (4) @(negedge clk);
    check("p_vsync_clks", 32'(vs_clks), 22);
    check("p_href_pulses", 32'(href_rises), 2);
    check("p_href_clks", 32'(href_clks), 32);
    check("p_line_period", 32'(href_rise_cyc[1] - href_rise_cyc[0]), 22);
    check("p_fd_latency", 32'(fd_cyc[0] - vs_rise_cyc[0]), 110);
    check("p_fd_count", 32'(fd_cnt), 1);
    check("p_no_ready", 32'(rdy_clks), 0);
    check("p_idle_at_fd", 32'(fd_busy), 0);
    check("p_state_idle", 32'(bus.state_dbg), 0);
    check("p_queue_empty", 32'(exp_q.size()), 0);

    // source frame, always valid
    bus.pattern_en = 1'b0;
    clear_mon();
    push_src_frame(1'b0);
    pulse_start();
    wait_fd(1, 400);
    repeat (4) @(negedge clk);
    check("s_ready_pulses", 32'(rdy_rises), 8);
    check("s_ready_clks", 32'(rdy_clks), 8);
    check("s_underrun", 32'(bus.underrun), 0);
    check("s_queue_empty", 32'(exp_q.size()), 0);

    // third pixel missing, then a clean frame
    clear_mon();
    drop_en = 1'b1;
    push_src_frame(1'b1);
    pulse_start();
    wait_fd(1, 400);
    drop_en = 1'b0;
    repeat (4) @(negedge clk);
    check("u_underrun_set", 32'(bus.underrun), 1);
    check("u_queue_empty", 32'(exp_q.size()), 0);
    clear_mon();
    push_src_frame(1'b0);
    pulse_start();
    wait_fd(1, 400);
    repeat (4) @(negedge clk);
    check("u_underrun_sticky", 32'(bus.underrun), 1);
    check("u_queue_empty2", 32'(exp_q.size()), 0);

    // continuous: two back-to-back frames
    bus.pattern_en = 1'b1;
    bus.continuous = 1'b1;
    clear_mon();
    push_pattern_frame();
    push_pattern_frame();
    pulse_start();
    wait_fd(1, 400);
    bus.continuous = 1'b0;
    wait_fd(2, 400);
    repeat (4) @(negedge clk);
    check("c_vsync_rises", 32'(vs_rises), 2);
    check("c_vsync_at_fd", 32'(fd_vs[0]), 1);
    check("c_vsync_follows_fd", 32'(vs_rise_cyc[1] - fd_cyc[0]), 0);
    check("c_no_idle_gap", 32'(idle_gap), 0);
    check("c_queue_empty", 32'(exp_q.size()), 0);

    // reset during second active line
    clear_mon();
    push_pattern_frame();
    pulse_start();
    n = 0;
    while (!(bus.y_count == 9'd1 && bus.href_out) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("r_reached_line1", 32'(n < 400), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("r_outputs_zero", {bus.pclk_out, bus.vsync_out, bus.href_out, bus.data_out,
                             bus.frame_done, bus.underrun, bus.pix_ready}, 0);
    check("r_busy", 32'(bus.busy), 0);
    check("r_counts", {bus.x_count, bus.y_count}, 0);
    reset = 1'b0;
    exp_q.delete();
    repeat (60) @(negedge clk);
    check("r_no_frame_done", 32'(fd_cnt), 0);
    clear_mon();
    push_pattern_frame();
    pulse_start();
    wait_fd(1, 400);
    repeat (4) @(negedge clk);
    check("r_new_frame_href", 32'(href_clks), 32);
    check("r_new_frame_queue", 32'(exp_q.size()), 0);

    // start while busy is ignored
    clear_mon();
    push_pattern_frame();
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    wait_fd(1, 400);
    repeat (200) @(negedge clk);
    check("b_one_frame", 32'(fd_cnt), 1);
    check("b_one_vsync", 32'(vs_rises), 1);
    check("b_idle", 32'(bus.busy), 0);
    check("b_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ov7670_stream_tx.md
OV7670_STREAM_TX -- requirements
Module: ov7670_stream_tx

Interface
REQ-001 Parameters SHALL be, one per line:
  H_ACTIVE, 640, pixels per active line
  V_ACTIVE, 480, active lines per frame
  H_BLANK, 144, pclk periods of href-low blanking after each line's active bytes
  VSYNC_LINES, 3, lines with vsync high
  V_BACK, 17, blank lines after vsync, before the first active line
  V_FRONT, 10, blank lines after the last active line
REQ-002 Ports SHALL be, one per line:
  clk  in  1  system clock, all logic on rising edge
  reset  in  1  synchronous, active-high
  start  in  1  request one frame; sampled only while idle
  continuous  in  1  when high at frame end, the next frame begins with no idle slot
  pattern_en  in  1  1 = internal test pattern, 0 = pixels from pix_data
  pix_data  in  16  RGB565 source pixel
  pix_valid  in  1  pix_data holds a valid pixel
  pix_ready  out  1  transfer strobe; a pixel is consumed when pix_valid and pix_ready are both high at an edge
  pclk_out  out  1  camera pixel clock, clk/2
  vsync_out  out  1  frame sync, active high
  href_out  out  1  line-valid, active high
  data_out  out  8  byte bus
  x_count  out  10  pixel index of the byte pair in flight
  y_count  out  9  active-line index
  busy  out  1  frame in progress
  frame_done  out  1  one-clk pulse at frame end
  underrun  out  1  sticky; source failed to supply a pixel

Function
REQ-003 pclk_out SHALL toggle on every clk edge from the first edge after reset deassertion.
REQ-004 A slot is one pclk_out period; all slot updates (state, counters, vsync_out, href_out, data_out) SHALL occur only on the edge where pclk_out goes 1->0, so outputs are stable at the pclk_out rising edge.
REQ-005 The FSM SHALL have the states IDLE, VSYNC, VBACK, ACTIVE, HBLANK and VFRONT.
REQ-006 IDLE->VSYNC SHALL occur on the first slot edge with start high.
REQ-007 Every line SHALL last 2*H_ACTIVE+H_BLANK slots in every state.
REQ-008 VSYNC SHALL last VSYNC_LINES lines and VBACK SHALL last V_BACK lines.
REQ-009 Each of the V_ACTIVE active lines SHALL be ACTIVE for 2*H_ACTIVE slots, then HBLANK for H_BLANK slots.
REQ-010 VFRONT SHALL last V_FRONT lines, then go to VSYNC if continuous is high, else to IDLE.
REQ-011 vsync_out SHALL be high exactly during VSYNC; href_out SHALL be high exactly during ACTIVE.
REQ-012 data_out SHALL be 0x00 whenever href_out is low.
REQ-013 Each pixel SHALL occupy two consecutive ACTIVE slots: pixel[15:8] first, then pixel[7:0].
REQ-014 When pattern_en=0, pix_ready SHALL be high for exactly the one clk cycle ending at the edge that launches a pixel's high byte; the accepted pix_data SHALL be held internally for the low byte.
REQ-015 If pix_valid is low at that edge, the pixel SHALL be sent as 0x0000 and underrun SHALL set; underrun clears only on reset.
REQ-016 When pattern_en=1, pix_ready SHALL stay 0 and the pixel SHALL be {y_count[4:0], x_count[5:0], x_count[4:0]}.
REQ-017 pattern_en SHALL be sampled once per line, at ACTIVE entry.
REQ-018 x_count SHALL increment after each low byte and wrap to 0 at line end; y_count SHALL increment after each active line and wrap to 0 at frame end.
REQ-019 busy SHALL be high in every state except IDLE.
REQ-020 frame_done SHALL pulse one clk on the edge leaving VFRONT.
REQ-021 start SHALL be ignored while busy.

Reset
REQ-022 On reset, all outputs SHALL be 0, the state SHALL be IDLE, and the counters SHALL be 0.
REQ-023 Reset mid-frame SHALL take effect on the same edge and SHALL abort the frame without a frame_done pulse.

Verification
REQ-024 The bench SHALL use H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, and SHALL cover:
  single frame, pattern_en=1, start pulse -> line = 11 slots; vsync high 22 clk; 2 href pulses of 16 clk each; frame_done 110 clk after the first VSYNC slot edge; back to IDLE
  pattern_en=0, source always valid with pix_data=0xA5C3 -> bytes A5,C3 repeated; 8 pix_ready pulses per frame; underrun stays 0
  pix_valid dropped for the 3rd pixel -> that pixel's bytes are 00,00; underrun=1 and held across the next frame
  continuous=1 -> the second frame's vsync rises on the edge right after the first frame's frame_done; no IDLE slot in between
  reset asserted during the second active line -> next edge: all outputs 0, busy 0, no frame_done; a new start produces a complete frame
  start re-asserted while busy -> ignored; exactly one frame produced
